modexp_ladder_ctrl: RTL and testbench
=====================================

# modexp_ladder_ctrl

Parametrised Montgomery-ladder modular exponentiation controller computing x^e mod M in constant-time ladder form over an arbitrary WIDTH. It drives two external Montgomery multipliers through start/done ports, so any multiplier with the same handshake can be attached. Compared with the fixed 1024-bit ladder, it adds configurable width, an optional leading-zero skip, an explicit `busy`/`err` status, and correct handling of zero-length exponents.

## Interface
- `WIDTH`, 1024: operand width; R = 2^WIDTH.
- `CNT_W`, 11: width of `lene`; must satisfy 2^CNT_W > WIDTH.
- `clk  in  1`: single clock, rising edge.
- `resetn  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle request; sampled only in IDLE.
- `in_x, in_m, in_r, in_r2  in  WIDTH each`: base, modulus, R mod M, R^2 mod M; held stable by the host while `busy`.
- `in_e  in  WIDTH`: exponent; captured on accepted start.
- `lene  in  CNT_W`: number of exponent bits processed, e[lene-1] down to e[0]; captured on start.
- `skip_lz  in  1`: mode bit, captured on start; 1 = skip leading zero bits before the ladder.
- `mul0_start, mul1_start  out  1`: one-cycle multiplier start pulses.
- `mul0_a, mul0_b, mul1_a, mul1_b  out  WIDTH each`: operands, stable from start until the matching done.
- `mul_m  out  WIDTH`: equals `in_m`.
- `mul0_done, mul1_done  in  1`: one-cycle done pulses; result valid in the same cycle.
- `mul0_res, mul1_res  in  WIDTH each`: Montgomery products a·b·R^-1 mod M.
- `result  out  WIDTH`: x^e mod M; updated only when `done` rises.
- `done  out  1`: registered one-cycle pulse.
- `busy  out  1`: high from the cycle after an accepted start until the cycle `done` is high, inclusive.
- `err  out  1`: qualified by `done`; high when `lene > WIDTH`.

## Operation
- Internal registers: A and X (WIDTH bits each), captured exponent E, bit index `idx` (CNT_W bits), and sticky done flags f0/f1.
- **IDLE, on `start`:**
  - Capture E, `lene` and `skip_lz`; load A <= in_r.
  - If `lene > WIDTH`: go to DONE with err=1; `result` <= 0; no multiplier starts.
  - Otherwise go to INIT.
- **INIT:** mul0_start with (in_x, in_r2), then INIT_WAIT.
- **INIT_WAIT:** on mul0_done, X <= mul0_res (x·R). Then:
  - `lene == 0`: go to FINAL.
  - `skip_lz`: go to SKIP.
  - Otherwise: go to STEP with idx = lene-1.
- **SKIP (one cycle per bit):**
  - E[idx]=1: go to STEP.
  - Else if idx=0: go to FINAL.
  - Else: idx--.
  - Skipping is exact, because a zero bit applied to (A=R, X=xR) leaves both unchanged.
- **STEP:** pulse both multiplier starts and clear f0/f1.
  - E[idx]=1: mul0 = (A, X), mul1 = (X, X).
  - E[idx]=0: mul0 = (A, X), mul1 = (A, A).
- **STEP_WAIT:**
  - all_done = (f0|mul0_done) & (f1|mul1_done). Dones may arrive in either order or in the same cycle.
  - On all_done with E[idx]=1: A <= mul0 result, X <= mul1 result.
  - On all_done with E[idx]=0: X <= mul0 result, A <= mul1 result.
  - Results are taken from the captured copy if the done arrived earlier.
  - Then: idx=0 goes to FINAL; otherwise idx-- and go to STEP.
- **FINAL:** mul0_start with (A, 1).
- **FINAL_WAIT:** on mul0_done, `result` <= mul0_res, then DONE.
- **DONE:** `done`=1 for this cycle, then IDLE.
- Multiplier dones outside the WAIT states are ignored.
- `start` while `busy` is ignored.

## Timing
- Reset (asynchronous, any state, including mid-operation):
  - State returns to IDLE.
  - `done`, `busy`, `err`, `mul0_start`, `mul1_start` = 0; `result` = 0; A, X, flags cleared.
  - Multiplier done pulses arriving after reset release are ignored.
- Latency uses multiplier latency L (start at t, done at t+L), with start sampled in cycle 0:
  - No skip: `done` high in cycle 3 + 2L + lene·(L+1).
  - Skip mode with z leading zeros and at least one 1 bit: 3 + 2L + (lene−z)·(L+1) + (z+1).
  - Skip mode with E=0: 3 + 2L + lene.
  - Error path: `done` in cycle 2.
- Operands are registered and stable from the start pulse until the matching done.
- `result` holds its value until the next `done`.
- A new `start` is accepted in the cycle after `done`.

## Test plan
Bench setup: WIDTH=8, behavioural multiplier with L=5, M=13, in_r=9, in_r2=3, x=5.
- e=11, lene=4, skip_lz=0 -> result=8, err=0, `done` in cycle 37, `busy` high cycles 1..37.
- e=11, lene=8, skip_lz=1 -> result=8, `done` in cycle 42. Same with skip_lz=0 -> result=8, `done` in cycle 61.
- e=0, lene=4 and lene=0 -> result=1 in both cases.
- lene=9 -> `done` in cycle 2, err=1, result=0, no `mul*_start` pulses.
- mul1 done 3 cycles before mul0, then same-cycle dones, with `start` pulsed while busy -> result still 8 and the extra `start` is ignored.
- resetn low mid-STEP_WAIT -> all outputs 0 immediately, stray done ignored; a fresh run with e=11 gives result 8.

Source files
------------

// File: rtl/modexp_ladder_ctrl.sv
// Montgomery-ladder modular exponentiation controller: computes x^e mod M by
// sequencing two external Montgomery multipliers through start/done handshakes.
module modexp_ladder_ctrl #(
    parameter int unsigned WIDTH = 1024,
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_r2,
    input  logic [WIDTH-1:0] in_e,
    input  logic [CNT_W-1:0] lene,
    input  logic             skip_lz,
    output logic             mul0_start,
    output logic             mul1_start,
    output logic [WIDTH-1:0] mul0_a,
    output logic [WIDTH-1:0] mul0_b,
    output logic [WIDTH-1:0] mul1_a,
    output logic [WIDTH-1:0] mul1_b,
    output logic [WIDTH-1:0] mul_m,
    input  logic             mul0_done,
    input  logic             mul1_done,
    input  logic [WIDTH-1:0] mul0_res,
    input  logic [WIDTH-1:0] mul1_res,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ERR,
        ST_INIT,
        ST_INIT_WAIT,
        ST_SKIP,
        ST_STEP,
        ST_STEP_WAIT,
        ST_FINAL,
        ST_FINAL_WAIT,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, x_q, x_d, e_q, e_d;
    logic [WIDTH-1:0] r0_q, r0_d, r1_q, r1_d;
    logic [CNT_W-1:0] lene_q, lene_d, idx_q, idx_d;
    logic             skip_q, skip_d, f0_q, f0_d, f1_q, f1_d, bit_q;

    logic [WIDTH-1:0] result_d, mul0_a_d, mul0_b_d, mul1_a_d, mul1_b_d;
    logic             done_d, busy_d, err_d, mul0_start_d, mul1_start_d;

    logic [WIDTH-1:0] res0, res1, e_shift;
    logic             all_done, nbit;

    assign mul_m = in_m;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state, next datapath values, and next registered outputs.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        x_d      = x_q;
        e_d      = e_q;
        lene_d   = lene_q;
        skip_d   = skip_q;
        idx_d    = idx_q;
        f0_d     = f0_q;
        f1_d     = f1_q;
        r0_d     = r0_q;
        r1_d     = r1_q;
        result_d = result;
        err_d    = 1'b0;

        // A done that arrived earlier in this step was parked in r0/r1.
        res0     = f0_q ? r0_q : mul0_res;
        res1     = f1_q ? r1_q : mul1_res;
        all_done = (f0_q | mul0_done) & (f1_q | mul1_done);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    e_d    = in_e;
                    lene_d = lene;
                    skip_d = skip_lz;
                    a_d    = in_r;
                    state_d = (lene > CNT_W'(WIDTH)) ? ST_ERR : ST_INIT;
                end
            end
            ST_ERR: begin
                result_d = '0;
                err_d    = 1'b1;
                state_d  = ST_DONE;
            end
            ST_INIT: state_d = ST_INIT_WAIT;
            ST_INIT_WAIT: begin
                if (mul0_done) begin
                    x_d   = mul0_res;
                    idx_d = lene_q - CNT_W'(1);
                    if (lene_q == '0) state_d = ST_FINAL;
                    else if (skip_q)  state_d = ST_SKIP;
                    else              state_d = ST_STEP;
                end
            end
            ST_SKIP: begin
                if (bit_q)             state_d = ST_STEP;
                else if (idx_q == '0)  state_d = ST_FINAL;
                else                   idx_d = idx_q - CNT_W'(1);
            end
            ST_STEP: begin
                f0_d    = 1'b0;
                f1_d    = 1'b0;
                state_d = ST_STEP_WAIT;
            end
            ST_STEP_WAIT: begin
                if (mul0_done && !f0_q) begin
                    f0_d = 1'b1;
                    r0_d = mul0_res;
                end
                if (mul1_done && !f1_q) begin
                    f1_d = 1'b1;
                    r1_d = mul1_res;
                end
                if (all_done) begin
                    if (bit_q) begin
                        a_d = res0;
                        x_d = res1;
                    end else begin
                        x_d = res0;
                        a_d = res1;
                    end
                    if (idx_q == '0) begin
                        state_d = ST_FINAL;
                    end else begin
                        idx_d   = idx_q - CNT_W'(1);
                        state_d = ST_STEP;
                    end
                end
            end
            ST_FINAL: state_d = ST_FINAL_WAIT;
            ST_FINAL_WAIT: begin
                if (mul0_done) begin
                    result_d = mul0_res;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        e_shift = e_d >> idx_d;
        nbit    = e_shift[0];

        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);

        // Start pulses and operands are launched on entry to the issuing state.
        mul0_start_d = 1'b0;
        mul1_start_d = 1'b0;
        mul0_a_d     = mul0_a;
        mul0_b_d     = mul0_b;
        mul1_a_d     = mul1_a;
        mul1_b_d     = mul1_b;
        case (state_d)
            ST_INIT: begin
                mul0_start_d = 1'b1;
                mul0_a_d     = in_x;
                mul0_b_d     = in_r2;
            end
            ST_STEP: begin
                mul0_start_d = 1'b1;
                mul1_start_d = 1'b1;
                mul0_a_d     = a_d;
                mul0_b_d     = x_d;
                mul1_a_d     = nbit ? x_d : a_d;
                mul1_b_d     = nbit ? x_d : a_d;
            end
            ST_FINAL: begin
                mul0_start_d = 1'b1;
                mul0_a_d     = a_d;
                mul0_b_d     = WIDTH'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q        <= '0;
            x_q        <= '0;
            e_q        <= '0;
            r0_q       <= '0;
            r1_q       <= '0;
            lene_q     <= '0;
            idx_q      <= '0;
            skip_q     <= 1'b0;
            f0_q       <= 1'b0;
            f1_q       <= 1'b0;
            bit_q      <= 1'b0;
            result     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            mul0_start <= 1'b0;
            mul1_start <= 1'b0;
            mul0_a     <= '0;
            mul0_b     <= '0;
            mul1_a     <= '0;
            mul1_b     <= '0;
        end else begin
            a_q        <= a_d;
            x_q        <= x_d;
            e_q        <= e_d;
            r0_q       <= r0_d;
            r1_q       <= r1_d;
            lene_q     <= lene_d;
            idx_q      <= idx_d;
            skip_q     <= skip_d;
            f0_q       <= f0_d;
            f1_q       <= f1_d;
            bit_q      <= nbit;
            result     <= result_d;
            done       <= done_d;
            busy       <= busy_d;
            err        <= err_d;
            mul0_start <= mul0_start_d;
            mul1_start <= mul1_start_d;
            mul0_a     <= mul0_a_d;
            mul0_b     <= mul0_b_d;
            mul1_a     <= mul1_a_d;
            mul1_b     <= mul1_b_d;
        end
    end

endmodule

// File: tb/tb_modexp_ladder_ctrl.sv
// Scoreboard bench for modexp_ladder_ctrl with behavioural Montgomery multipliers
// and a plain-arithmetic reference for results and latency.
module tb_modexp_ladder_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  in_x = '0, in_m = '0, in_r = '0, in_r2 = '0, in_e = '0;
    logic [CW-1:0] lene = '0;
    logic          skip_lz = 1'b0;
    logic          mul0_start, mul1_start;
    logic [W-1:0]  mul0_a, mul0_b, mul1_a, mul1_b, mul_m;
    logic          mul0_done = 1'b0, mul1_done = 1'b0;
    logic [W-1:0]  mul0_res = '0, mul1_res = '0;
    logic [W-1:0]  result;
    logic          done, busy, err;

    modexp_ladder_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_m(in_m), .in_r(in_r), .in_r2(in_r2), .in_e(in_e),
        .lene(lene), .skip_lz(skip_lz),
        .mul0_start(mul0_start), .mul1_start(mul1_start),
        .mul0_a(mul0_a), .mul0_b(mul0_b), .mul1_a(mul1_a), .mul1_b(mul1_b),
        .mul_m(mul_m),
        .mul0_done(mul0_done), .mul1_done(mul1_done),
        .mul0_res(mul0_res), .mul1_res(mul1_res),
        .result(result), .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           c0;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_ex;

    int errors = 0, checks = 0;
    int cyc = 0, done_seen = 0, n_mstart = 0, busy_cnt = 0;
    int m_cur = 13, rinv = 3;
    int lat0 = 5, lat1 = 5;
    int m0_cnt = 0, m1_cnt = 0;
    logic [W-1:0] m0_a = '0, m0_b = '0, m1_a = '0, m1_b = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = (int'(a) * int'(b)) % m_cur;
        return W'((p * rinv) % m_cur);
    endfunction

    function automatic int ref_pow(input int x, input int n, input int m);
        int r = 1 % m;
        for (int k = 0; k < n; k++) r = (r * x) % m;
        return r;
    endfunction

    task automatic set_modulus(input int m);
        int r;
        m_cur = m;
        for (int i = 1; i < m; i++) if ((i * 256) % m == 1) rinv = i;
        r     = 256 % m;
        in_m  = W'(m);
        in_r  = W'(r);
        in_r2 = W'((r * r) % m);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Montgomery multipliers with independent latencies.
    always @(posedge clk) begin
        mul0_done <= 1'b0;
        if (m0_cnt == 1) begin
            mul0_done <= 1'b1;
            mul0_res  <= mont(m0_a, m0_b);
            m0_cnt    <= 0;
            if (busy) chk("mul0_operands_stable", {mul0_a, mul0_b}, {m0_a, m0_b});
        end else if (m0_cnt > 1) begin
            m0_cnt <= m0_cnt - 1;
        end
        if (mul0_start) begin
            m0_a <= mul0_a;
            m0_b <= mul0_b;
            if (lat0 == 1) begin
                mul0_done <= 1'b1;
                mul0_res  <= mont(mul0_a, mul0_b);
            end else begin
                m0_cnt <= lat0 - 1;
            end
        end
    end

    always @(posedge clk) begin
        mul1_done <= 1'b0;
        if (m1_cnt == 1) begin
            mul1_done <= 1'b1;
            mul1_res  <= mont(m1_a, m1_b);
            m1_cnt    <= 0;
            if (busy) chk("mul1_operands_stable", {mul1_a, mul1_b}, {m1_a, m1_b});
        end else if (m1_cnt > 1) begin
            m1_cnt <= m1_cnt - 1;
        end
        if (mul1_start) begin
            m1_a <= mul1_a;
            m1_b <= mul1_b;
            if (lat1 == 1) begin
                mul1_done <= 1'b1;
                mul1_res  <= mont(mul1_a, mul1_b);
            end else begin
                m1_cnt <= lat1 - 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!resetn) begin
            busy_cnt = 0;
        end else begin
            if (mul0_start) n_mstart++;
            if (mul1_start) n_mstart++;
            if (busy) busy_cnt++;
            if (done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending request", cyc);
                end else begin
                    mon_ex = sb.pop_front();
                    chk("result", result, mon_ex.res);
                    chk("err", err, mon_ex.err);
                    chk("done_cycle", cyc - mon_ex.c0, mon_ex.lat);
                    chk("busy_cycles", busy_cnt, mon_ex.lat);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic run(input int x, input int e, input int len, input int sk, input bit extra);
        exp_t ex;
        int eff, msb, z, lm, base, prev;
        @(posedge clk);
        #1;
        in_x    = W'(x);
        in_e    = W'(e);
        lene    = CW'(len);
        skip_lz = sk[0];
        eff     = (len >= int'(W)) ? e : (e & ((1 << len) - 1));
        lm      = (lat0 > lat1) ? lat0 : lat1;
        base    = 3 + 2 * lat0;
        if (len > int'(W)) begin
            ex.res = '0;
            ex.err = 1'b1;
            ex.lat = 2;
        end else begin
            ex.res = W'(ref_pow(x, eff, m_cur));
            ex.err = 1'b0;
            if (sk == 0) begin
                ex.lat = base + len * (lm + 1);
            end else if (eff == 0) begin
                ex.lat = base + len;
            end else begin
                msb = 0;
                for (int b = 0; b < len; b++) if (((eff >> b) & 1) != 0) msb = b;
                z      = len - 1 - msb;
                ex.lat = base + (len - z) * (lm + 1) + z + 1;
            end
        end
        ex.c0 = cyc;
        prev  = done_seen;
        sb.push_back(ex);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (extra) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < 3000 && done_seen == prev; i++) @(posedge clk);
        if (done_seen == prev) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after 3000 cycles, required done for e=%0d lene=%0d", e, len);
            void'(sb.pop_back());
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_mul0_start"}, mul0_start, 0);
        chk({tag, "_mul1_start"}, mul1_start, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, required bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, m;
        set_modulus(13);
        #1 resetn = 1'b0;
        #1 chk_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        run(5, 11, 4, 0, 1'b0);
        run(5, 11, 8, 1, 1'b0);
        run(5, 11, 8, 0, 1'b0);
        run(5, 0, 4, 0, 1'b0);
        run(5, 0, 0, 0, 1'b0);
        run(5, 0, 4, 1, 1'b0);
        run(5, 0, 0, 1, 1'b0);

        s = n_mstart;
        run(5, 11, 9, 0, 1'b0);
        chk("err_no_mul_start", n_mstart - s, 0);

        // Out-of-order dones, then same-cycle dones, each with a start while busy.
        lat1 = 2;
        d = done_seen;
        run(5, 11, 4, 0, 1'b1);
        repeat (20) @(posedge clk);
        chk("extra_start_ignored_ooo", done_seen - d, 1);
        lat1 = 5;
        d = done_seen;
        run(5, 11, 4, 0, 1'b1);
        repeat (20) @(posedge clk);
        chk("extra_start_ignored_same", done_seen - d, 1);
        lat0 = 2;
        run(5, 11, 8, 1, 1'b0);
        lat0 = 5;

        // Reset in the middle of the first ladder step.
        @(posedge clk);
        #1;
        in_e = 8'd11; lene = 4'd4; skip_lz = 1'b0; start = 1'b1;
        d = done_seen;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 resetn = 1'b0;
        #1 chk_idle_outputs("midreset");
        @(posedge clk);
        #1 resetn = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("stray_done_busy", busy, 0);
        chk("stray_done_no_done", done_seen - d, 0);
        chk("stray_done_result", result, 0);
        run(5, 11, 4, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            m = 2 * int'($urandom_range(1, 127)) + 1;
            set_modulus(m);
            lat0 = int'($urandom_range(1, 6));
            lat1 = int'($urandom_range(1, 6));
            run(int'($urandom_range(0, m - 1)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 10)), int'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
